// File: rtl/pcm_pkg.sv
// pcm_pkg
// Shared types and helpers for the PCM frame packer.
//   packer_state_t    : frame FSM states (IDLE, HDR_SYNC, HDR_SEQ, DATA)
//   bytes_per_sample  : byte count of one sample of width w (w is a multiple of 8)
//   MAX_CH            : largest supported channel count
//   SYNC_DEFAULT      : default frame marker byte
package pcm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_SYNC = 2'd1,
        HDR_SEQ  = 2'd2,
        DATA     = 2'd3
    } packer_state_t;

    localparam int MAX_CH = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic int bytes_per_sample(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer
// Packs one multi-channel PCM sample set into a framed byte stream for an
// 8-bit transmit FIFO. Frame = [SYNC_BYTE, seq] (when SYNC_EN) followed by
// each enabled channel in ascending order, little-endian.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pcm_data_i          : channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   pcm_valid_i         : one-cycle strobe, all channels valid together
//   ch_enable_i         : channel mask, sampled with pcm_valid_i
//   fifo_full_i         : FIFO back-pressure
//   fifo_wr_en_o        : FIFO write strobe
//   fifo_write_data_o   : FIFO write byte
//   busy_o              : frame in progress
//   frame_count_o       : completed frames, wrapping
//   overrun_count_o     : samples dropped while busy, saturating
module pcm_frame_packer
    import pcm_pkg::*;
#(
    parameter int         NUM_CH       = 2,
    parameter int         SAMPLE_WIDTH = 16,
    parameter bit         SYNC_EN      = 1'b1,
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] pcm_data_i,
    input  logic                           pcm_valid_i,
    input  logic [NUM_CH-1:0]              ch_enable_i,
    input  logic                           fifo_full_i,
    output logic                           fifo_wr_en_o,
    output logic [7:0]                     fifo_write_data_o,
    output logic                           busy_o,
    output logic [31:0]                    frame_count_o,
    output logic [15:0]                    overrun_count_o
);

    localparam int BPS   = bytes_per_sample(SAMPLE_WIDTH);
    localparam int IDX_W = $clog2(2 + NUM_CH * BPS);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW    = NUM_CH * SAMPLE_WIDTH;
    localparam int SEL_W = $clog2(DW);

    packer_state_t     r_state;
    packer_state_t     w_nextState;
    logic [DW-1:0]     r_frameData;
    logic [NUM_CH-1:0] r_mask;
    logic [CH_W-1:0]   r_ch;
    logic [IDX_W-1:0]  r_byteIdx;
    logic [7:0]        r_seq;
    logic [31:0]       r_frameCount;
    logic [15:0]       r_overrunCount;

    logic [CH_W-1:0]   w_firstCh;
    logic              w_firstFound;
    logic [CH_W-1:0]   w_nextCh;
    logic              w_nextFound;
    logic [SEL_W-1:0]  w_bitSel;
    logic [7:0]        w_dataByte;
    logic              w_busy;
    logic              w_wrEn;
    logic              w_capture;
    logic              w_lastSampleByte;
    logic              w_frameDone;
    logic              w_strobe;

    // Channel search: the lowest enabled channel of the incoming mask starts a
    // frame, and the next enabled channel above the current one continues it.
    always_comb begin
        w_firstCh    = '0;
        w_firstFound = 1'b0;
        w_nextCh     = '0;
        w_nextFound  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_enable_i[c] && !w_firstFound) begin
                w_firstCh    = CH_W'(c);
                w_firstFound = 1'b1;
            end
            if (r_mask[c] && (c > int'(r_ch)) && !w_nextFound) begin
                w_nextCh    = CH_W'(c);
                w_nextFound = 1'b1;
            end
        end
    end

    // Handshake and frame bookkeeping. A frame ends on the write of the last
    // byte of the last enabled channel.
    always_comb begin
        w_busy           = (r_state != IDLE);
        w_wrEn           = w_busy & ~fifo_full_i;
        w_strobe         = pcm_valid_i & (|ch_enable_i);
        w_capture        = (r_state == IDLE) & w_strobe;
        w_lastSampleByte = (r_byteIdx == IDX_W'(BPS - 1));
        w_frameDone      = (r_state == DATA) & w_wrEn & w_lastSampleByte & ~w_nextFound;
        w_bitSel         = SEL_W'((int'(r_ch) * BPS + int'(r_byteIdx)) * 8);
        w_dataByte       = r_frameData[w_bitSel +: 8];
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and output byte. Header states only advance on an accepted
    // write, so back-pressure simply freezes the current byte on the bus.
    always_comb begin
        w_nextState       = r_state;
        fifo_write_data_o = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_nextState = SYNC_EN ? HDR_SYNC : DATA;
                end
            end
            HDR_SYNC: begin
                fifo_write_data_o = SYNC_BYTE;
                if (w_wrEn) begin
                    w_nextState = HDR_SEQ;
                end
            end
            HDR_SEQ: begin
                fifo_write_data_o = r_seq;
                if (w_wrEn) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                fifo_write_data_o = w_dataByte;
                if (w_frameDone) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Frame registers, byte walker and counters. Strobes arriving while a frame
    // is in flight (including its final byte cycle) are dropped and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameData    <= '0;
            r_mask         <= '0;
            r_ch           <= '0;
            r_byteIdx      <= '0;
            r_seq          <= 8'h00;
            r_frameCount   <= 32'd0;
            r_overrunCount <= 16'd0;
        end else begin
            if (w_capture) begin
                r_frameData <= pcm_data_i;
                r_mask      <= ch_enable_i;
                r_ch        <= w_firstCh;
                r_byteIdx   <= '0;
            end else if ((r_state == DATA) && w_wrEn) begin
                if (w_lastSampleByte) begin
                    r_byteIdx <= '0;
                    if (w_nextFound) begin
                        r_ch <= w_nextCh;
                    end
                end else begin
                    r_byteIdx <= r_byteIdx + 1'b1;
                end
            end
            if (w_frameDone) begin
                r_frameCount <= r_frameCount + 32'd1;
                r_seq        <= r_seq + 8'd1;
            end
            if (w_strobe && w_busy && (r_overrunCount != 16'hFFFF)) begin
                r_overrunCount <= r_overrunCount + 16'd1;
            end
        end
    end

    assign fifo_wr_en_o    = w_wrEn;
    assign busy_o          = w_busy;
    assign frame_count_o   = r_frameCount;
    assign overrun_count_o = r_overrunCount;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// tb_pcm_frame_packer
// Bench for pcm_frame_packer. A queue-based frame model predicts every byte,
// the busy/write handshake and both counters; literal frames pin the model.
// A second instance covers the 4-channel, 24-bit, header-less build.
module tb_pcm_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pcmData = '0;
    logic        pcmValid = 1'b0;
    logic [1:0]  chEnable = '0;
    logic        fifoFull = 1'b0;
    logic        wrEn;
    logic [7:0]  wrData;
    logic        busy;
    logic [31:0] frameCount;
    logic [15:0] overrunCount;

    logic [95:0] pcmData2 = '0;
    logic        pcmValid2 = 1'b0;
    logic [3:0]  chEnable2 = '0;
    logic        fifoFull2 = 1'b0;
    logic        wrEn2;
    logic [7:0]  wrData2;
    logic        busy2;
    logic [31:0] frameCount2;
    logic [15:0] overrunCount2;

    int assertCount = 0;
    int failCount = 0;
    int cyc = 0;

    logic [7:0] expQ[$];
    logic [7:0] mSeq = 8'h00;
    int         mFrames = 0;
    int         mOver = 0;
    bit         mBusy;

    logic [7:0] logQ[$];
    int         logCyc[$];
    logic [7:0] logQ2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pcm_frame_packer #(
        .NUM_CH(2), .SAMPLE_WIDTH(16), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pcm_data_i(pcmData), .pcm_valid_i(pcmValid),
        .ch_enable_i(chEnable), .fifo_full_i(fifoFull), .fifo_wr_en_o(wrEn),
        .fifo_write_data_o(wrData), .busy_o(busy), .frame_count_o(frameCount),
        .overrun_count_o(overrunCount)
    );

    pcm_frame_packer #(
        .NUM_CH(4), .SAMPLE_WIDTH(24), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .pcm_data_i(pcmData2), .pcm_valid_i(pcmValid2),
        .ch_enable_i(chEnable2), .fifo_full_i(fifoFull2), .fifo_wr_en_o(wrEn2),
        .fifo_write_data_o(wrData2), .busy_o(busy2), .frame_count_o(frameCount2),
        .overrun_count_o(overrunCount2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame model: a whole frame is queued at capture time and one byte leaves
    // per accepted write; the frame completes when its queue drains.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            mSeq = 8'h00;
            mFrames = 0;
            mOver = 0;
        end else begin
            mBusy = (expQ.size() != 0);
            if (pcmValid && (chEnable != 2'b00)) begin
                if (mBusy) begin
                    if (mOver < 65535) mOver++;
                end else begin
                    expQ.push_back(8'hA5);
                    expQ.push_back(mSeq);
                    for (int c = 0; c < 2; c++)
                        if (chEnable[c])
                            for (int b = 0; b < 2; b++)
                                expQ.push_back(pcmData[c*16 + b*8 +: 8]);
                end
            end
            if (mBusy && !fifoFull) begin
                void'(expQ.pop_front());
                if (expQ.size() == 0) begin
                    mFrames++;
                    mSeq = mSeq + 8'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy", {31'd0, busy}, {31'd0, expQ.size() != 0});
            checkOutput("wr_en", {31'd0, wrEn}, {31'd0, (expQ.size() != 0) && !fifoFull});
            checkOutput("wr_data", {24'd0, wrData}, {24'd0, (expQ.size() != 0) ? expQ[0] : 8'h00});
            checkOutput("frame_count", frameCount, mFrames);
            checkOutput("overrun_count", {16'd0, overrunCount}, mOver);
            if (wrEn) begin
                logQ.push_back(wrData);
                logCyc.push_back(cyc);
            end
            if (wrEn2) logQ2.push_back(wrData2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m);
        pcmData  = d;
        chEnable = m;
        pcmValid = 1'b1;
        tick();
        pcmValid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (!busy) return;
            tick();
        end
        checkOutput("waitIdle timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic clearLog();
        logQ.delete();
        logCyc.delete();
    endtask

    // Expected bytes are packed first-byte-most-significant in exp.
    task automatic checkLog(input string name, input logic [7:0] q[$], input logic [63:0] exp, input int n);
        logic [7:0] act;
        checkOutput({name, " length"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            act = (i < q.size()) ? q[i] : 8'hxx;
            checkOutput($sformatf("%s byte%0d", name, i), {24'd0, act}, {24'd0, exp[(n-1-i)*8 +: 8]});
        end
    endtask

    initial begin
        int startCyc;

        // Reset state
        #12;
        checkOutput("reset wr_en", {31'd0, wrEn}, 32'd0);
        checkOutput("reset data", {24'd0, wrData}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset frame_count", frameCount, 32'd0);
        checkOutput("reset overrun", {16'd0, overrunCount}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full two-channel frame at full rate
        clearLog();
        startCyc = cyc;
        applyStimulus(32'hABCD_1234, 2'b11);
        waitIdle(50);
        checkLog("t1", logQ, 64'h0000_A500_3412_CDAB, 6);
        if (logCyc.size() == 6) begin
            checkOutput("t1 latency", logCyc[0], startCyc + 1);
            checkOutput("t1 span", logCyc[5] - logCyc[0], 5);
        end
        checkOutput("t1 frame_count", frameCount, 32'd1);

        // Single upper channel, then an empty-mask strobe
        clearLog();
        applyStimulus(32'h5AA5_0000, 2'b10);
        waitIdle(50);
        checkLog("t2", logQ, 64'h0000_0000_A501_A55A, 4);
        clearLog();
        applyStimulus(32'hFFFF_FFFF, 2'b00);
        repeat (5) tick();
        checkOutput("t2 empty writes", logQ.size(), 0);
        checkOutput("t2 frame_count", frameCount, 32'd2);
        checkOutput("t2 overrun", {16'd0, overrunCount}, 32'd0);

        // Back-pressure for 3 cycles after the second byte
        clearLog();
        applyStimulus(32'hABCD_1234, 2'b11);
        tick();
        tick();
        fifoFull = 1'b1;
        repeat (3) tick();
        fifoFull = 1'b0;
        waitIdle(50);
        checkLog("t3", logQ, 64'h0000_A502_3412_CDAB, 6);
        if (logCyc.size() == 6) checkOutput("t3 span", logCyc[5] - logCyc[0], 8);

        // Overrun during byte 3, then saturation
        clearLog();
        applyStimulus(32'hABCD_1234, 2'b11);
        repeat (3) tick();
        applyStimulus(32'h1111_2222, 2'b11);
        waitIdle(50);
        checkLog("t4", logQ, 64'h0000_A503_3412_CDAB, 6);
        checkOutput("t4 overrun", {16'd0, overrunCount}, 32'd1);
        clearLog();
        applyStimulus(32'hABCD_1234, 2'b01);
        waitIdle(50);
        checkLog("t4 next", logQ, 64'h0000_0000_A504_3412, 4);
        applyStimulus(32'hABCD_1234, 2'b11);
        fifoFull = 1'b1;
        pcmValid = 1'b1;
        repeat (65540) tick();
        pcmValid = 1'b0;
        checkOutput("t4 saturate", {16'd0, overrunCount}, 32'h0000_FFFF);
        fifoFull = 1'b0;
        waitIdle(50);

        // Reset at byte 4 of a frame
        clearLog();
        applyStimulus(32'hABCD_1234, 2'b11);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 wr_en", {31'd0, wrEn}, 32'd0);
        checkOutput("t5 busy", {31'd0, busy}, 32'd0);
        checkOutput("t5 data", {24'd0, wrData}, 32'd0);
        checkOutput("t5 overrun", {16'd0, overrunCount}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clearLog();
        applyStimulus(32'hABCD_1234, 2'b11);
        waitIdle(50);
        checkLog("t5 restart", logQ, 64'h0000_A500_3412_CDAB, 6);
        checkOutput("t5 frame_count", frameCount, 32'd1);

        // Header-less 4-channel 24-bit build
        logQ2.delete();
        pcmData2  = 96'h000000_112233_000000_0A0B0C;
        chEnable2 = 4'b0101;
        pcmValid2 = 1'b1;
        tick();
        pcmValid2 = 1'b0;
        for (int i = 0; i < 20 && busy2; i++) tick();
        checkLog("t6", logQ2, 64'h0000_0C0B_0A33_2211, 6);
        checkOutput("t6 frame_count", frameCount2, 32'd1);

        // Sequence wrap over 256 frames with random data and masks
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int f = 0; f < 257; f++) begin
            clearLog();
            applyStimulus($urandom, 2'($urandom_range(1, 3)));
            waitIdle(50);
            if (f == 255) checkOutput("seq FF", {24'd0, logQ[1]}, 32'h0000_00FF);
            if (f == 256) checkOutput("seq wrap", {24'd0, logQ[1]}, 32'd0);
        end
        checkOutput("wrap frame_count", frameCount, 32'd257);

        // Random traffic with back-pressure and overruns
        for (int i = 0; i < 400; i++) begin
            pcmValid = ($urandom_range(0, 3) == 0);
            chEnable = 2'($urandom);
            pcmData  = $urandom;
            fifoFull = ($urandom_range(0, 4) == 0);
            tick();
        end
        pcmValid = 1'b0;
        fifoFull = 1'b0;
        waitIdle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
